// File: rtl/udp_rx_pkg.sv
// Shared types and constants for the UDP receive frame buffer.
package udp_rx_pkg;

  localparam int unsigned UDP_HDR_BYTES = 8;
  localparam int unsigned LEN_W         = 16;
  localparam int unsigned WORD_W        = 32;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_OUT   = 2'd2
  } rd_state_e;

  // Descriptor record: {word count (aw+1 bits), payload byte length}
  function automatic int unsigned desc_w(input int unsigned aw);
    return aw + 1 + LEN_W;
  endfunction

endpackage

// File: rtl/udp_rx_frame_buffer_if.sv
// Replay stream from the frame buffer to the processing chain.
interface udp_rx_frame_buffer_if;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [15:0] m_len;

  modport master (output m_data, output m_valid, output m_last, output m_len, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, input m_len, output m_ready);
endinterface

// File: rtl/udp_rx_word_ram.sv
// Simple dual-port word RAM, registered read port, latency 1, storage not reset.
module udp_rx_word_ram #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/udp_rx_frame_buffer.sv
// Holds received UDP payload frames until complete, commits them to a circular
// word buffer and replays committed frames over a valid/ready stream.
module udp_rx_frame_buffer
  import udp_rx_pkg::*;
#(
  parameter int unsigned AW = 9,
  parameter int unsigned LW = 3
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 frame_start,
  input  logic [WORD_W-1:0]    word_in,
  input  logic                 word_valid,
  input  logic                 frame_end,
  input  logic [LEN_W-1:0]     frame_len,
  udp_rx_frame_buffer_if.master m,
  output logic [15:0]          frames_ok,
  output logic [15:0]          frames_dropped,
  output logic [AW:0]          buf_level
);

  localparam int unsigned PW     = AW + 1;
  localparam int unsigned DESC_W = desc_w(AW);
  localparam int unsigned DDEPTH = 1 << LW;
  localparam logic [AW:0] FULL_LVL      = {1'b1, {AW{1'b0}}};
  localparam logic [LW:0] DESC_FULL_LVL = {1'b1, {LW{1'b0}}};

  logic [AW:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] cnt_q, cnt_d, rem_q, rem_d, buf_level_q;
  logic        ovf_q, ovf_d;
  logic [15:0] frames_ok_q, frames_ok_d, frames_dropped_q, frames_dropped_d;

  logic [DESC_W-1:0] desc_mem [0:DDEPTH-1];
  logic [LW:0]       desc_wr_q, desc_rd_q;
  logic [DESC_W-1:0] desc_wdata, desc_rdata;
  logic              desc_push, desc_pop, desc_empty, desc_full;

  logic              ram_we, ram_re;
  logic [AW-1:0]     ram_waddr, ram_raddr;
  logic [WORD_W-1:0] ram_rdata;

  rd_state_e         state_q, state_d;
  logic              m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [WORD_W-1:0] m_data_q, m_data_d;
  logic [LEN_W-1:0]  m_len_q, m_len_d;
  logic [AW:0]       rd_next;
  logic              wr_full;

  assign desc_empty = (desc_wr_q == desc_rd_q);
  assign desc_full  = ((desc_wr_q - desc_rd_q) == DESC_FULL_LVL);
  assign desc_rdata = desc_mem[desc_rd_q[LW-1:0]];
  assign rd_next    = rd_ptr_q + PW'(1);

  udp_rx_word_ram #(.AW(AW), .DW(WORD_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (word_in),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Write side: abort, word capture, then commit/rollback on frame_end
  always_comb begin
    wr_ptr_d         = wr_ptr_q;
    commit_ptr_d     = commit_ptr_q;
    cnt_d            = cnt_q;
    ovf_d            = ovf_q;
    frames_ok_d      = frames_ok_q;
    frames_dropped_d = frames_dropped_q;
    ram_we           = 1'b0;
    ram_waddr        = wr_ptr_q[AW-1:0];
    desc_push        = 1'b0;
    desc_wdata       = '0;
    wr_full          = 1'b0;

    if (frame_start) begin
      wr_ptr_d = commit_ptr_q;
      ovf_d    = 1'b0;
      cnt_d    = '0;
    end

    wr_full = ((wr_ptr_d - rd_ptr_q) == FULL_LVL);
    if (word_valid) begin
      if (wr_full || ovf_d) begin
        ovf_d = 1'b1;
      end else begin
        ram_we    = 1'b1;
        ram_waddr = wr_ptr_d[AW-1:0];
        wr_ptr_d  = wr_ptr_d + PW'(1);
        cnt_d     = cnt_d + PW'(1);
      end
    end

    if (frame_end) begin
      if (ovf_d || desc_full || (cnt_d == '0) || (frame_len < LEN_W'(UDP_HDR_BYTES + 1))) begin
        wr_ptr_d = commit_ptr_q;
        // An empty frame is silently ignored rather than counted as a drop
        if ((ovf_d || (cnt_d != '0)) && (frames_dropped_q != 16'hFFFF))
          frames_dropped_d = frames_dropped_q + 16'd1;
      end else begin
        commit_ptr_d = wr_ptr_d;
        desc_push    = 1'b1;
        desc_wdata   = {cnt_d, frame_len - LEN_W'(UDP_HDR_BYTES)};
        frames_ok_d  = frames_ok_q + 16'd1;
      end
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  // Read FSM next-state and output staging
  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    rem_d     = rem_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    m_len_d   = m_len_q;
    desc_pop  = 1'b0;
    ram_re    = 1'b0;
    ram_raddr = rd_ptr_q[AW-1:0];

    case (state_q)
      RD_IDLE: begin
        if (!desc_empty) begin
          desc_pop = 1'b1;
          rem_d    = desc_rdata[DESC_W-1 -: PW];
          m_len_d  = desc_rdata[LEN_W-1:0];
          ram_re   = 1'b1;
          state_d  = RD_FETCH;
        end
      end
      RD_FETCH: begin
        m_valid_d = 1'b1;
        m_data_d  = ram_rdata;
        m_last_d  = (rem_q == PW'(1));
        state_d   = RD_OUT;
      end
      RD_OUT: begin
        if (m_valid_q && m.m_ready) begin
          m_valid_d = 1'b0;
          rd_ptr_d  = rd_next;
          if (m_last_q) begin
            m_last_d = 1'b0;
            state_d  = RD_IDLE;
          end else begin
            rem_d     = rem_q - PW'(1);
            ram_re    = 1'b1;
            ram_raddr = rd_next[AW-1:0];
            state_d   = RD_FETCH;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q         <= '0;
      commit_ptr_q     <= '0;
      rd_ptr_q         <= '0;
      cnt_q            <= '0;
      rem_q            <= '0;
      ovf_q            <= 1'b0;
      frames_ok_q      <= '0;
      frames_dropped_q <= '0;
      buf_level_q      <= '0;
      desc_wr_q        <= '0;
      desc_rd_q        <= '0;
      state_q          <= RD_IDLE;
      m_valid_q        <= 1'b0;
      m_last_q         <= 1'b0;
      m_data_q         <= '0;
      m_len_q          <= '0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      commit_ptr_q     <= commit_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      cnt_q            <= cnt_d;
      rem_q            <= rem_d;
      ovf_q            <= ovf_d;
      frames_ok_q      <= frames_ok_d;
      frames_dropped_q <= frames_dropped_d;
      buf_level_q      <= commit_ptr_q - rd_ptr_q;
      if (desc_push) desc_wr_q <= desc_wr_q + (LW+1)'(1);
      if (desc_pop)  desc_rd_q <= desc_rd_q + (LW+1)'(1);
      state_q          <= state_d;
      m_valid_q        <= m_valid_d;
      m_last_q         <= m_last_d;
      m_data_q         <= m_data_d;
      m_len_q          <= m_len_d;
    end
  end

  always_ff @(posedge clk) begin
    if (desc_push) desc_mem[desc_wr_q[LW-1:0]] <= desc_wdata;
  end

  assign m.m_valid      = m_valid_q;
  assign m.m_last       = m_last_q;
  assign m.m_data       = m_data_q;
  assign m.m_len        = m_len_q;
  assign frames_ok      = frames_ok_q;
  assign frames_dropped = frames_dropped_q;
  assign buf_level      = buf_level_q;

endmodule

// File: tb/tb_udp_rx_frame_buffer.sv
// Scoreboard bench for udp_rx_frame_buffer: small buffer (8 words, 2 descriptors).
module tb_udp_rx_frame_buffer;

  localparam int unsigned AW    = 3;
  localparam int unsigned LW    = 1;
  localparam int          DEPTH = 1 << AW;
  // One popped frame is held at the output, so this many may wait in total
  localparam int          FRAME_CAP = (1 << LW) + 1;

  logic        clk = 1'b0;
  logic        clr;
  logic        frame_start, word_valid, frame_end;
  logic [31:0] word_in;
  logic [15:0] frame_len;
  logic [15:0] frames_ok, frames_dropped;
  logic [AW:0] buf_level;

  udp_rx_frame_buffer_if sif();

  udp_rx_frame_buffer #(.AW(AW), .LW(LW)) dut (
    .clk            (clk),
    .clr            (clr),
    .frame_start    (frame_start),
    .word_in        (word_in),
    .word_valid     (word_valid),
    .frame_end      (frame_end),
    .frame_len      (frame_len),
    .m              (sif),
    .frames_ok      (frames_ok),
    .frames_dropped (frames_dropped),
    .buf_level      (buf_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [15:0] len;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   exp_ok = 0;
  int   exp_drop = 0;
  int   model_used = 0;
  int   model_waiting = 0;
  int   consumed = 0;
  int   ready_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [7:0] base, input int i);
    logic [7:0] b;
    b = base + 8'(4 * i);
    return {b + 8'd1, b + 8'd2, b + 8'd3, b + 8'd4};
  endfunction

  // Ready driver: 0 always, 1 random, 2 held low, 3 pattern 1,0,0,1
  initial begin
    int cyc = 0;
    sif.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: sif.m_ready = 1'b1;
        1: sif.m_ready = 1'($urandom_range(0, 1));
        2: sif.m_ready = 1'b0;
        default: sif.m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
      cyc++;
    end
  end

  // Monitor: handshake scoreboard plus stall-stability checks
  initial begin
    logic        have_prev = 1'b0;
    logic        prev_v = 1'b0, prev_r = 1'b0;
    logic [48:0] prev_bus = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (clr) begin
        have_prev = 1'b0;
      end else begin
        if (have_prev && prev_v && !prev_r) begin
          check("stall_valid", 64'(sif.m_valid), 64'd1);
          check("stall_bus", 64'({sif.m_data, sif.m_last, sif.m_len}), 64'(prev_bus));
        end
        if (sif.m_valid && sif.m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_word: got 0x%0h, expected no word", sif.m_data);
          end else begin
            e = exp_q.pop_front();
            check("m_data", 64'(sif.m_data), 64'(e.data));
            check("m_last", 64'(sif.m_last), 64'(e.last));
            check("m_len", 64'(sif.m_len), 64'(e.len));
            consumed++;
            model_used--;
            if (e.last) model_waiting--;
          end
        end
        prev_v    = sif.m_valid;
        prev_r    = sif.m_ready;
        prev_bus  = {sif.m_data, sif.m_last, sif.m_len};
        have_prev = 1'b1;
      end
    end
  end

  task automatic send_words(input int n, input logic [7:0] base, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) tick();
      word_valid = 1'b1;
      word_in    = mk(base, i);
      tick();
      word_valid = 1'b0;
    end
  endtask

  // Drives one frame and records the outcome the buffer rules predict
  task automatic send_frame(input int n, input logic [15:0] len, input logic [7:0] base, input bit gaps);
    exp_t e;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    send_words(n, base, gaps);
    frame_end = 1'b1;
    frame_len = len;
    tick();
    frame_end = 1'b0;
    if (n == 0) begin
      // empty frame: neither committed nor counted
    end else if (n > DEPTH - model_used || len < 16'd9 || model_waiting >= FRAME_CAP) begin
      if (exp_drop < 65535) exp_drop++;
    end else begin
      for (int i = 0; i < n; i++) begin
        e.data = mk(base, i);
        e.last = (i == n - 1);
        e.len  = len - 16'd8;
        exp_q.push_back(e);
      end
      exp_ok++;
      model_used += n;
      model_waiting++;
    end
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      tick();
      t++;
    end
    if (exp_q.size() != 0) begin
      check({tag, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    repeat (4) tick();
    check({tag, "_frames_ok"}, 64'(frames_ok), 64'(exp_ok));
    check({tag, "_frames_dropped"}, 64'(frames_dropped), 64'(exp_drop));
    check({tag, "_buf_level"}, 64'(buf_level), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_m_valid"}, 64'(sif.m_valid), 64'd0);
    check({tag, "_m_last"}, 64'(sif.m_last), 64'd0);
    check({tag, "_m_data"}, 64'(sif.m_data), 64'd0);
    check({tag, "_m_len"}, 64'(sif.m_len), 64'd0);
    check({tag, "_frames_ok"}, 64'(frames_ok), 64'd0);
    check({tag, "_frames_dropped"}, 64'(frames_dropped), 64'd0);
    check({tag, "_buf_level"}, 64'(buf_level), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, t;
    clr = 1'b1; frame_start = 1'b0; word_valid = 1'b0; frame_end = 1'b0;
    word_in = '0; frame_len = '0;
    repeat (3) tick();
    check_reset_state("reset");
    clr = 1'b0;
    tick();

    // single frame
    ready_mode = 0;
    send_frame(4, 16'd24, 8'h00, 1'b0);
    drain("single");

    // abort: first partial frame discarded by a new frame_start
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    send_words(3, 8'h40, 1'b0);
    send_frame(2, 16'd16, 8'h80, 1'b0);
    drain("abort");

    // overflow, then a normal frame
    send_frame(10, 16'd48, 8'h20, 1'b0);
    drain("overflow");
    send_frame(2, 16'd16, 8'hA0, 1'b0);
    drain("after_ovf");

    // backpressure with two frames queued
    ready_mode = 2;
    send_frame(3, 16'd20, 8'h10, 1'b0);
    send_frame(3, 16'd20, 8'h50, 1'b0);
    ready_mode = 3;
    drain("backpressure");

    // descriptor FIFO full while output stalled
    ready_mode = 2;
    for (int f = 0; f < 4; f++) begin
      send_frame(2, 16'd16, 8'(8'hC0 + 8'(f * 16)), 1'b0);
      repeat (2) tick();
    end
    repeat (3) tick();
    check("descfull_dropped", 64'(frames_dropped), 64'(exp_drop));
    check("descfull_level", 64'(buf_level), 64'(model_used));
    ready_mode = 0;
    drain("descfull");

    // reset while the second word of a frame is stalled at the output
    ready_mode = 2;
    send_frame(4, 16'd24, 8'h60, 1'b0);
    c0 = consumed;
    t  = 0;
    ready_mode = 0;
    while (consumed == c0 && t < 100) begin
      tick();
      t++;
    end
    ready_mode = 2;
    if (consumed == c0) check("midreset_first_word_timeout", 64'(consumed), 64'(c0 + 1));
    repeat (3) tick();
    check("midreset_presenting", 64'(sif.m_valid), 64'd1);
    clr = 1'b1;
    tick();
    exp_q.delete();
    exp_ok = 0; exp_drop = 0; model_used = 0; model_waiting = 0;
    check_reset_state("midreset");
    clr = 1'b0;
    ready_mode = 0;
    send_frame(3, 16'd20, 8'h70, 1'b0);
    drain("post_reset");

    // randomized frames against the model
    ready_mode = 1;
    for (int k = 0; k < 30; k++) begin
      int          n;
      logic [15:0] len;
      logic [7:0]  base;
      if ($urandom_range(0, 3) == 0) begin
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        send_words($urandom_range(0, 3), 8'hEE, 1'b1);
      end
      n    = $urandom_range(0, 10);
      base = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       len = 16'($urandom_range(0, 8));
        1:       len = 16'($urandom_range(9, 300));
        default: len = 16'(n * 4 + 8);
      endcase
      send_frame(n, len, base, 1'b1);
      drain("random");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
